// File: rtl/if_fetch_unit_if.sv
// if_fetch_unit_if: bundle between the instruction-fetch unit and its
// surroundings (hazard unit, condition handler, instruction RAM, IF/ID).
//   PC_Enable      hazard-unit enable; word consumed when valid and enabled
//   Branch_Taken   redirect request
//   Branch_Target  redirect byte address (low two bits cleared on use)
//   Mem_Addr       byte address to instruction RAM
//   Mem_Data       RAM read byte for Mem_Addr, same cycle
//   Inst_Out       assembled big-endian instruction word
//   Inst_Valid     Inst_Out/PC_Out hold a complete word
//   PC_Out         address of Inst_Out
//   PC_4_Out       PC_Out + 4 (wraps mod 2^32)
//   Fetch_Busy     a word is being assembled
//   Align_Fault    sticky misaligned-redirect flag
// slave is the fetch unit's view; master is the environment's view.
interface if_fetch_unit_if #(
  parameter int ADDR_WIDTH = 8
);
  logic                  PC_Enable;
  logic                  Branch_Taken;
  logic [31:0]           Branch_Target;
  logic [ADDR_WIDTH-1:0] Mem_Addr;
  logic [7:0]            Mem_Data;
  logic [31:0]           Inst_Out;
  logic                  Inst_Valid;
  logic [31:0]           PC_Out;
  logic [31:0]           PC_4_Out;
  logic                  Fetch_Busy;
  logic                  Align_Fault;

  modport master (
    output PC_Enable, Branch_Taken, Branch_Target, Mem_Data,
    input  Mem_Addr, Inst_Out, Inst_Valid, PC_Out, PC_4_Out,
           Fetch_Busy, Align_Fault
  );

  modport slave (
    input  PC_Enable, Branch_Taken, Branch_Target, Mem_Data,
    output Mem_Addr, Inst_Out, Inst_Valid, PC_Out, PC_4_Out,
           Fetch_Busy, Align_Fault
  );
endinterface

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction-fetch front end. Owns the PC, reads the
// byte-wide instruction RAM one byte per cycle (BYTE0..BYTE3), assembles a
// big-endian word (byte at PC is the MSB) and holds it in HOLD until the
// hazard unit's PC_Enable consumes it. Branch_Taken redirects from any state
// and takes priority over consumption.
// Ports:
//   CLK  clock, rising edge
//   CLR  asynchronous active-high reset
//   bus  if_fetch_unit_if.slave (see interface file for signal list)
// Optional feature: define FETCH_ALIGN_CHECK_EN to make Align_Fault latch on
// a redirect whose target has nonzero low bits; otherwise it is tied to 0.
module if_fetch_unit #(
  parameter int          ADDR_WIDTH = 8,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic CLK,
  input  logic CLR,
  if_fetch_unit_if.slave bus
);

  typedef enum logic [2:0] {BYTE0, BYTE1, BYTE2, BYTE3, HOLD} state_t;

  state_t      state, state_next;
  logic [31:0] pc, pc_next;
  logic [31:0] inst, inst_next;
  logic [1:0]  offset;

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state <= BYTE0;
      pc    <= RESET_PC;
      inst  <= '0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      inst  <= inst_next;
    end
  end

  always_comb begin
    state_next = state;
    pc_next    = pc;
    inst_next  = inst;
    offset     = 2'd0;
    case (state)
      BYTE0: begin
        offset            = 2'd0;
        inst_next[31:24]  = bus.Mem_Data;
        state_next        = BYTE1;
      end
      BYTE1: begin
        offset            = 2'd1;
        inst_next[23:16]  = bus.Mem_Data;
        state_next        = BYTE2;
      end
      BYTE2: begin
        offset            = 2'd2;
        inst_next[15:8]   = bus.Mem_Data;
        state_next        = BYTE3;
      end
      BYTE3: begin
        offset            = 2'd3;
        inst_next[7:0]    = bus.Mem_Data;
        state_next        = HOLD;
      end
      HOLD: begin
        if (bus.PC_Enable) begin
          pc_next    = pc + 32'd4;
          state_next = BYTE0;
        end
      end
      default: state_next = BYTE0;
    endcase
    // Redirect overrides both byte capture and consumption; the partially
    // assembled word is simply abandoned and refilled from the target.
    if (bus.Branch_Taken) begin
      pc_next    = bus.Branch_Target & ~32'h3;
      state_next = BYTE0;
      inst_next  = inst;
    end
  end

  assign bus.Mem_Addr   = pc[ADDR_WIDTH-1:0] + ADDR_WIDTH'(offset);
  assign bus.Inst_Out   = inst;
  assign bus.Inst_Valid = (state == HOLD);
  assign bus.Fetch_Busy = (state != HOLD);
  assign bus.PC_Out     = pc;
  assign bus.PC_4_Out   = pc + 32'd4;

`ifdef FETCH_ALIGN_CHECK_EN
  logic align_fault;

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      align_fault <= 1'b0;
    end else if (bus.Branch_Taken && (bus.Branch_Target[1:0] != 2'b00)) begin
      align_fault <= 1'b1;
    end
  end

  assign bus.Align_Fault = align_fault;
`else
  assign bus.Align_Fault = 1'b0;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Testbench for if_fetch_unit: directed scenarios with literal expectations,
// then randomized enable/redirect traffic checked every cycle against a
// transaction-level model (PC plus count of bytes fetched so far; the
// expected word is read straight from the RAM image at the model PC).
module tb_if_fetch_unit;

  logic CLK;
  logic CLR;
  logic [7:0] ram [256];

  int checks   = 0;
  int failures = 0;
  bit started  = 0;

  if_fetch_unit_if #(.ADDR_WIDTH(8)) bus ();

  if_fetch_unit #(
    .ADDR_WIDTH (8),
    .RESET_PC   (32'h0000_0000)
  ) dut (
    .CLK (CLK),
    .CLR (CLR),
    .bus (bus)
  );

  assign bus.Mem_Data = ram[bus.Mem_Addr];

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] word_at(input logic [31:0] a);
    logic [7:0] b0, b1, b2, b3;
    b0 = a[7:0];
    b1 = b0 + 8'd1;
    b2 = b0 + 8'd2;
    b3 = b0 + 8'd3;
    return {ram[b0], ram[b1], ram[b2], ram[b3]};
  endfunction

  // Reference model: PC and number of bytes already fetched (4 = word held).
  logic [31:0] m_pc    = 32'h0;
  int          m_bytes = 0;
  bit          m_fault = 1'b0;

  always @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      m_pc    = 32'h0;
      m_bytes = 0;
      m_fault = 1'b0;
    end else if (bus.Branch_Taken) begin
`ifdef FETCH_ALIGN_CHECK_EN
      if (bus.Branch_Target[1:0] != 2'b00) m_fault = 1'b1;
`endif
      m_pc    = {bus.Branch_Target[31:2], 2'b00};
      m_bytes = 0;
    end else if (m_bytes == 4) begin
      if (bus.PC_Enable) begin
        m_pc    = m_pc + 32'd4;
        m_bytes = 0;
      end
    end else begin
      m_bytes = m_bytes + 1;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge CLK) begin
    if (started && !CLR) begin
      logic [31:0] exp_addr;
      exp_addr = m_pc + ((m_bytes < 4) ? m_bytes : 0);
      chk("valid",  {31'd0, bus.Inst_Valid}, {31'd0, m_bytes == 4});
      chk("busy",   {31'd0, bus.Fetch_Busy}, {31'd0, m_bytes != 4});
      chk("pc",     bus.PC_Out, m_pc);
      chk("pc4",    bus.PC_4_Out, m_pc + 32'd4);
      chk("addr",   {24'd0, bus.Mem_Addr}, {24'd0, exp_addr[7:0]});
      chk("fault",  {31'd0, bus.Align_Fault}, {31'd0, m_fault});
      if (m_bytes == 4) chk("inst", bus.Inst_Out, word_at(m_pc));
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic redirect(input logic [31:0] tgt);
    bus.Branch_Taken  = 1'b1;
    bus.Branch_Target = tgt;
    step();
    bus.Branch_Taken  = 1'b0;
  endtask

  initial begin
    for (int unsigned i = 0; i < 256; i++) ram[i] = 8'($urandom);
    ram[8'h00] = 8'hE3; ram[8'h01] = 8'hA0; ram[8'h02] = 8'h10; ram[8'h03] = 8'h05;
    ram[8'h40] = 8'hDE; ram[8'h41] = 8'hAD; ram[8'h42] = 8'hBE; ram[8'h43] = 8'hEF;
    ram[8'hFC] = 8'h12; ram[8'hFD] = 8'h34; ram[8'hFE] = 8'h56; ram[8'hFF] = 8'h78;

    bus.PC_Enable     = 1'b0;
    bus.Branch_Taken  = 1'b0;
    bus.Branch_Target = 32'h0;
    CLR = 1'b0;
    #2 CLR = 1'b1;
    #1;
    chk("rst_valid", {31'd0, bus.Inst_Valid}, 32'd0);
    chk("rst_busy",  {31'd0, bus.Fetch_Busy}, 32'd1);
    chk("rst_pc",    bus.PC_Out, 32'h0);
    chk("rst_addr",  {24'd0, bus.Mem_Addr}, 32'h0);
    chk("rst_inst",  bus.Inst_Out, 32'h0);
    chk("rst_fault", {31'd0, bus.Align_Fault}, 32'd0);
    @(negedge CLK);
    @(negedge CLK);
    CLR = 1'b0;
    started = 1'b1;

    // First fetch: valid in the 5th cycle after release.
    repeat (3) step();
    chk("first_not_yet", {31'd0, bus.Inst_Valid}, 32'd0);
    step();
    chk("first_valid", {31'd0, bus.Inst_Valid}, 32'd1);
    chk("first_inst",  bus.Inst_Out, 32'hE3A0_1005);
    chk("first_pc",    bus.PC_Out, 32'h0);
    chk("first_pc4",   bus.PC_4_Out, 32'h4);

    // Stall in HOLD.
    repeat (6) step();
    chk("stall_inst",  bus.Inst_Out, 32'hE3A0_1005);
    chk("stall_valid", {31'd0, bus.Inst_Valid}, 32'd1);
    bus.PC_Enable = 1'b1;
    step();
    bus.PC_Enable = 1'b0;
    chk("consume_pc",   bus.PC_Out, 32'h4);
    chk("consume_addr", {24'd0, bus.Mem_Addr}, 32'h04);

    // Redirect during BYTE2.
    repeat (2) step();
    redirect(32'h40);
    chk("redir_addr", {24'd0, bus.Mem_Addr}, 32'h40);
    repeat (4) step();
    chk("redir_valid", {31'd0, bus.Inst_Valid}, 32'd1);
    chk("redir_inst",  bus.Inst_Out, 32'hDEAD_BEEF);
    chk("redir_pc",    bus.PC_Out, 32'h40);

    // Redirect beats consume.
    bus.PC_Enable = 1'b1;
    redirect(32'h10);
    bus.PC_Enable = 1'b0;
    chk("redir_wins_pc", bus.PC_Out, 32'h10);

    // RAM address wrap.
    redirect(32'hFC);
    chk("wrap_a0", {24'd0, bus.Mem_Addr}, 32'hFC);
    step(); chk("wrap_a1", {24'd0, bus.Mem_Addr}, 32'hFD);
    step(); chk("wrap_a2", {24'd0, bus.Mem_Addr}, 32'hFE);
    step(); chk("wrap_a3", {24'd0, bus.Mem_Addr}, 32'hFF);
    step(); chk("wrap_inst", bus.Inst_Out, 32'h1234_5678);
    bus.PC_Enable = 1'b1;
    step();
    bus.PC_Enable = 1'b0;
    chk("wrap_pc",   bus.PC_Out, 32'h100);
    chk("wrap_addr", {24'd0, bus.Mem_Addr}, 32'h00);

    // 32-bit PC wrap.
    redirect(32'hFFFF_FFFC);
    chk("pc32_pc4", bus.PC_4_Out, 32'h0);
    repeat (4) step();
    bus.PC_Enable = 1'b1;
    step();
    bus.PC_Enable = 1'b0;
    chk("pc32_wrap", bus.PC_Out, 32'h0);

    // Misaligned redirect.
    redirect(32'h22);
    chk("misalign_pc", bus.PC_Out, 32'h20);
`ifdef FETCH_ALIGN_CHECK_EN
    chk("misalign_fault", {31'd0, bus.Align_Fault}, 32'd1);
`else
    chk("misalign_fault", {31'd0, bus.Align_Fault}, 32'd0);
`endif

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      bus.PC_Enable     = ($urandom_range(3) != 0);
      bus.Branch_Taken  = ($urandom_range(19) == 0);
      bus.Branch_Target = $urandom;
      step();
    end
    bus.Branch_Taken = 1'b0;
    bus.PC_Enable    = 1'b0;

    // Abort mid-fetch with asynchronous reset.
    redirect(32'h80);
    step();
    CLR = 1'b1;
    #1;
    chk("abort_pc",    bus.PC_Out, 32'h0);
    chk("abort_addr",  {24'd0, bus.Mem_Addr}, 32'h0);
    chk("abort_busy",  {31'd0, bus.Fetch_Busy}, 32'd1);
    chk("abort_fault", {31'd0, bus.Align_Fault}, 32'd0);
    @(negedge CLK);
    CLR = 1'b0;
    repeat (4) step();
    chk("refetch_inst", bus.Inst_Out, 32'hE3A0_1005);
    repeat (2) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
